dm_sized: RTL and testbench
===========================

// Module: dm_sized
// PURPOSE
//   Parametrised byte-addressed little-endian data memory for the MIPS CPU datapath.
//   Successor to the fixed-depth lb/sb data memory. Supports byte, half and word
//   loads/stores with sign or zero extension, and registered one-cycle reads.
//   Also provides a hardware clear sequencer after reset, and error flagging for
//   misaligned, reserved-size and out-of-range accesses.
// PARAMETERS
//   ADDR_W       32    width of addr port (byte address)
//   DEPTH_WORDS  3072  number of 32-bit words stored (3072 = 12288 bytes)
//   INIT_CLEAR   1     1: zero every word after reset; 0: skip clear, contents undefined
// PORTS
//   clk       in   1       clock, all state changes on posedge
//   rst       in   1       asynchronous reset, active-high
//   mem_wr    in   1       store request this cycle
//   mem_rd    in   1       load request this cycle
//   size      in   2       00 byte, 01 half, 10 word, 11 reserved (error)
//   sign_ext  in   1       loads: 1 sign-extend, 0 zero-extend (ignored for word)
//   addr      in   ADDR_W  byte address
//   data_in   in   32      store data, LSB-aligned (byte in [7:0], half in [15:0])
//   data_out  out  32      load result, registered
//   rd_valid  out  1       1-cycle pulse: data_out updated by a load
//   busy      out  1       clear sequence running; requests ignored
//   err       out  1       1-cycle pulse: previous-cycle request rejected
// BEHAVIOUR
//   Reset (rst=1, async): data_out=0, rd_valid=0, err=0, busy=1, clear pointer=0.
//     FSM is forced to CLEAR (INIT_CLEAR=1) or IDLE (INIT_CLEAR=0).
//   FSM CLEAR: each posedge writes mem[ptr]=0 and increments ptr.
//     On the posedge that clears ptr=DEPTH_WORDS-1, the FSM goes to IDLE and busy=0.
//     busy is high for exactly DEPTH_WORDS cycles after rst falls.
//   INIT_CLEAR=0: busy falls at the first posedge after rst deasserts.
//   rst asserted mid-clear: outputs reset at once; the clear restarts from word 0.
//   FSM IDLE: service requests. While busy, mem_wr/mem_rd are ignored (no err).
//   Word index = addr[ADDR_W-1:2].
//   A request is rejected if any of the following hold:
//     - size=11;
//     - size=01 and addr[0]=1;
//     - size=10 and addr[1:0]!=0;
//     - index >= DEPTH_WORDS.
//   A rejected request causes no write, no rd_valid and no data_out change.
//     err=1 on the next cycle, for one cycle.
//   Store (posedge): write the addressed lane(s) only; other bytes are untouched.
//     byte -> lane addr[1:0]; half -> lanes {addr[1],1} and {addr[1],0}; word -> all four lanes.
//   Load: latency 1. Request at edge N gives data_out and rd_valid=1 after edge N.
//     data_out then holds until the next accepted load.
//     byte/half: the selected lane is moved to LSBs and extended per sign_ext.
//   mem_wr and mem_rd both high: the write is performed and the read is read-first
//     (returns the pre-write contents). A rejected request rejects both.
//   rd_valid and err are never both 1.
// TESTING
//   1 rst high 3 cycles, release -> busy=1 for 3072 cycles then 0; lw 0x0, 0x2FFC -> 0x00000000.
//   2 sw 0x87654321 @0x10, then loads:
//       lb 0x13 -> 0xFFFFFF87; lbu 0x13 -> 0x00000087;
//       lh 0x12 -> 0xFFFF8765; lhu 0x10 -> 0x00004321; rd_valid 1 cycle each.
//   3 sb 0x000000AA @0x11, then lw 0x10 -> 0x8765AA21.
//     sh 0x0000BEEF @0x12, then lw 0x10 -> 0xBEEFAA21.
//   4 Rejected requests -> err pulse 1 cycle, rd_valid=0, memory unchanged (lw 0x10 unchanged):
//       lw @0x12; sh @0x11; size=11 @0x10; sw @0x3000.
//   5 mem_wr=mem_rd=1, sw 0x11111111 @0x20 (old 0x0) -> data_out=0x0; next lw 0x20 -> 0x11111111.
//   6 rst pulsed when ptr~100 -> busy stays 1, outputs 0, clear restarts, busy low 3072 cycles
//       after release; requests during busy -> no rd_valid, no err, no write.

Source files
------------

// File: rtl/dm_sized.sv
// Byte-addressed little-endian data memory with byte/half/word access, sign/zero
// extended one-cycle loads, a post-reset clear sequencer and request error flagging.
module dm_sized #(
  parameter int unsigned ADDR_W      = 32,
  parameter int unsigned DEPTH_WORDS = 3072,
  parameter bit          INIT_CLEAR  = 1'b1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              mem_wr,
  input  logic              mem_rd,
  input  logic [1:0]        size,
  input  logic              sign_ext,
  input  logic [ADDR_W-1:0] addr,
  input  logic [31:0]       data_in,
  output logic [31:0]       data_out,
  output logic              rd_valid,
  output logic              busy,
  output logic              err
);

  localparam int unsigned IDX_W  = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
  localparam int unsigned WIDX_W = ADDR_W - 2;

  localparam logic [1:0] SZ_BYTE = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_WORD = 2'b10;

  typedef enum logic {S_CLEAR, S_IDLE} state_t;

  logic [31:0]      mem_q [DEPTH_WORDS];

  state_t           state_q, state_d;
  logic [IDX_W-1:0] ptr_q, ptr_d;
  logic             busy_q, busy_d;
  logic [31:0]      data_out_q, data_out_d;
  logic             rd_valid_q, rd_valid_d;
  logic             err_q, err_d;

  logic [WIDX_W-1:0] word_idx_c;
  logic [IDX_W-1:0]  idx_c;
  logic [1:0]        lane_c;
  logic              in_range_c;
  logic              misalign_c;
  logic              bad_size_c;
  logic              reject_c;
  logic              req_c;
  logic              accept_c;
  logic              reject_ev_c;
  logic              store_c;
  logic              load_c;
  logic              mem_clr_c;
  logic [3:0]        be_c;
  logic [31:0]       wdata_c;
  logic [31:0]       rword_c;
  logic [31:0]       rshift_c;
  logic [31:0]       load_val_c;

  // Request decode and legality
  always_comb begin
    word_idx_c = addr[ADDR_W-1:2];
    idx_c      = word_idx_c[IDX_W-1:0];
    lane_c     = addr[1:0];
    in_range_c = (word_idx_c < WIDX_W'(DEPTH_WORDS));
    bad_size_c = (size == 2'b11);
    misalign_c = ((size == SZ_HALF) && addr[0]) ||
                 ((size == SZ_WORD) && (addr[1:0] != 2'b00));
    reject_c   = bad_size_c || misalign_c || !in_range_c;
    req_c      = mem_wr || mem_rd;
    // busy_q gates both paths so nothing is accepted or flagged during the clear
    accept_c    = !busy_q && req_c && !reject_c;
    reject_ev_c = !busy_q && req_c && reject_c;
    store_c     = accept_c && mem_wr;
    load_c      = accept_c && mem_rd;
  end

  // Store lane enables and lane-replicated write data
  always_comb begin
    be_c    = 4'b0000;
    wdata_c = data_in;
    unique case (size)
      SZ_BYTE: begin
        be_c    = 4'(4'b0001 << lane_c);
        wdata_c = {4{data_in[7:0]}};
      end
      SZ_HALF: begin
        be_c    = lane_c[1] ? 4'b1100 : 4'b0011;
        wdata_c = {2{data_in[15:0]}};
      end
      SZ_WORD: begin
        be_c    = 4'b1111;
        wdata_c = data_in;
      end
      default: begin
        be_c    = 4'b0000;
        wdata_c = data_in;
      end
    endcase
  end

  // Load lane select and extension; reads pre-edge contents (read-first)
  always_comb begin
    rword_c    = mem_q[idx_c];
    rshift_c   = rword_c >> {lane_c, 3'b000};
    load_val_c = rword_c;
    unique case (size)
      SZ_BYTE: load_val_c = sign_ext ? {{24{rshift_c[7]}}, rshift_c[7:0]}
                                     : {24'h000000, rshift_c[7:0]};
      SZ_HALF: load_val_c = sign_ext ? {{16{rshift_c[15]}}, rshift_c[15:0]}
                                     : {16'h0000, rshift_c[15:0]};
      default: load_val_c = rword_c;
    endcase
  end

  // Next-state and output logic
  always_comb begin
    state_d    = state_q;
    ptr_d      = ptr_q;
    busy_d     = busy_q;
    data_out_d = data_out_q;
    rd_valid_d = 1'b0;
    err_d      = 1'b0;
    mem_clr_c  = 1'b0;
    unique case (state_q)
      S_CLEAR: begin
        mem_clr_c = 1'b1;
        busy_d    = 1'b1;
        ptr_d     = ptr_q + IDX_W'(1);
        if (ptr_q == IDX_W'(DEPTH_WORDS - 1)) begin
          state_d = S_IDLE;
          busy_d  = 1'b0;
          ptr_d   = '0;
        end
      end
      S_IDLE: begin
        busy_d = 1'b0;
        err_d  = reject_ev_c;
        if (load_c) begin
          data_out_d = load_val_c;
          rd_valid_d = 1'b1;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // Control and output registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= INIT_CLEAR ? S_CLEAR : S_IDLE;
      ptr_q      <= '0;
      busy_q     <= 1'b1;
      data_out_q <= '0;
      rd_valid_q <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      ptr_q      <= ptr_d;
      busy_q     <= busy_d;
      data_out_q <= data_out_d;
      rd_valid_q <= rd_valid_d;
      err_q      <= err_d;
    end
  end

  // Storage array: clear sequencer has priority, otherwise lane-masked stores
  always_ff @(posedge clk) begin
    if (mem_clr_c) begin
      mem_q[ptr_q] <= '0;
    end else if (store_c) begin
      for (int i = 0; i < 4; i++) begin
        if (be_c[i]) begin
          mem_q[idx_c][8*i +: 8] <= wdata_c[8*i +: 8];
        end
      end
    end
  end

  assign data_out = data_out_q;
  assign rd_valid = rd_valid_q;
  assign busy     = busy_q;
  assign err      = err_q;

endmodule

// File: tb/tb_dm_sized.sv
// Scoreboard bench for dm_sized: byte-array reference model, directed and random
// requests, clear-sequencer timing and mid-clear reset.
module tb_dm_sized;

  localparam int unsigned DEPTH  = 3072;
  localparam int unsigned NBYTES = DEPTH * 4;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        mem_wr = 1'b0;
  logic        mem_rd = 1'b0;
  logic [1:0]  size = 2'b00;
  logic        sign_ext = 1'b0;
  logic [31:0] addr = 32'h0;
  logic [31:0] data_in = 32'h0;
  logic [31:0] data_out;
  logic        rd_valid;
  logic        busy;
  logic        err;

  dm_sized dut (
    .clk      (clk),
    .rst      (rst),
    .mem_wr   (mem_wr),
    .mem_rd   (mem_rd),
    .size     (size),
    .sign_ext (sign_ext),
    .addr     (addr),
    .data_in  (data_in),
    .data_out (data_out),
    .rd_valid (rd_valid),
    .busy     (busy),
    .err      (err)
  );

  always #5 clk = ~clk;

  typedef struct {
    int unsigned due;
    bit          is_err;
    logic [31:0] data;
  } exp_t;

  exp_t        q[$];
  logic [7:0]  mm [NBYTES];
  int          total = 0;
  int          bad = 0;
  int unsigned cyc = 0;
  logic [31:0] exp_dout = 32'h0;
  bit          tb_busy = 1'b1;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic void check(string nm, logic [31:0] act, logic [31:0] want);
    total++;
    if (act !== want) begin
      bad++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", nm, act, want, cyc);
    end
  endfunction

  function automatic logic [31:0] model_load(logic [1:0] sz, bit sx, int unsigned a);
    logic [31:0] v;
    case (sz)
      2'd0: begin
        v = 32'(mm[a]);
        if (sx && v >= 32'd128) v = v + 32'hFFFF_FF00;
      end
      2'd1: begin
        v = 32'(mm[a]) + 32'(mm[a+1]) * 32'd256;
        if (sx && v >= 32'd32768) v = v + 32'hFFFF_0000;
      end
      default: begin
        v = 32'(mm[a]) + 32'(mm[a+1]) * 32'd256 +
            32'(mm[a+2]) * 32'd65536 + 32'(mm[a+3]) * 32'd16777216;
      end
    endcase
    return v;
  endfunction

  function automatic void model_store(logic [1:0] sz, int unsigned a, logic [31:0] d);
    int unsigned n;
    n = (sz == 2'd0) ? 1 : (sz == 2'd1) ? 2 : 4;
    for (int k = 0; k < int'(n); k++) mm[a + k] = d[8*k +: 8];
  endfunction

  task automatic issue(bit wr, bit rd, logic [1:0] sz, bit sx, logic [31:0] a, logic [31:0] d);
    exp_t e;
    bit   rej;
    mem_wr   = wr;
    mem_rd   = rd;
    size     = sz;
    sign_ext = sx;
    addr     = a;
    data_in  = d;
    if (!tb_busy && (wr || rd)) begin
      rej = (sz == 2'd3) || (sz == 2'd1 && a[0]) || (sz == 2'd2 && a[1:0] != 2'b00) ||
            ((a >> 2) >= DEPTH);
      e.due = cyc + 1;
      if (rej) begin
        e.is_err = 1'b1;
        e.data   = 32'h0;
        q.push_back(e);
      end else begin
        if (rd) begin
          e.is_err = 1'b0;
          e.data   = model_load(sz, sx, int'(a));
          q.push_back(e);
        end
        if (wr) model_store(sz, int'(a), d);
      end
    end
    @(negedge clk);
  endtask

  task automatic idle(int n);
    mem_wr = 1'b0;
    mem_rd = 1'b0;
    repeat (n) @(negedge clk);
  endtask

  task automatic reset_seq(int hold);
    mem_wr = 1'b0;
    mem_rd = 1'b0;
    @(negedge clk);
    #2 rst = 1'b1;
    #1;
    check("rst_data_out", data_out, 32'h0);
    check("rst_rd_valid", 32'(rd_valid), 32'h0);
    check("rst_err", 32'(err), 32'h0);
    check("rst_busy", 32'(busy), 32'h1);
    q.delete();
    exp_dout = 32'h0;
    tb_busy  = 1'b1;
    for (int i = 0; i < int'(NBYTES); i++) mm[i] = 8'h00;
    repeat (hold) @(negedge clk);
    #2 rst = 1'b0;
  endtask

  task automatic wait_clear();
    int cnt;
    #1;
    cnt = busy ? 1 : 0;
    while (cnt > 0 && cnt < 5000) begin
      @(negedge clk);
      if (busy) cnt++;
      else break;
    end
    if (cnt == 0) @(negedge clk);
    check("busy_cycles", 32'(cnt), 32'(DEPTH));
    tb_busy = 1'b0;
  endtask

  // Monitor: pops expectations as the DUT presents responses
  initial begin : monitor
    exp_t e;
    forever begin
      @(negedge clk);
      if (!rst) begin
        if (rd_valid && err) check("both_valid_err", 32'h1, 32'h0);
        while (q.size() > 0 && q[0].due < cyc) begin
          e = q.pop_front();
          check(e.is_err ? "missing_err" : "missing_rd_valid", 32'h0, 32'h1);
        end
        if (q.size() > 0 && q[0].due == cyc) begin
          e = q.pop_front();
          if (e.is_err) begin
            check("err_pulse", 32'(err), 32'h1);
            check("rd_valid_on_err", 32'(rd_valid), 32'h0);
            check("hold_on_err", data_out, exp_dout);
          end else begin
            check("rd_valid", 32'(rd_valid), 32'h1);
            check("load_data", data_out, e.data);
            exp_dout = e.data;
          end
        end else begin
          if (rd_valid || err) check("unexpected_out", {30'h0, rd_valid, err}, 32'h0);
          check("data_hold", data_out, exp_dout);
        end
      end
    end
  end

  initial begin : watchdog
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin : stim
    logic [31:0] a;
    logic [1:0]  sz;
    int unsigned r;

    // Power-on reset and full clear
    rst = 1'b1;
    repeat (3) @(negedge clk);
    reset_seq(3);
    wait_clear();
    issue(0, 1, 2'd2, 0, 32'h0, 32'h0);
    issue(0, 1, 2'd2, 0, 32'h2FFC, 32'h0);
    idle(2);

    // Word store then narrow loads
    issue(1, 0, 2'd2, 0, 32'h10, 32'h87654321);
    issue(0, 1, 2'd0, 1, 32'h13, 32'h0);
    issue(0, 1, 2'd0, 0, 32'h13, 32'h0);
    issue(0, 1, 2'd1, 1, 32'h12, 32'h0);
    issue(0, 1, 2'd1, 0, 32'h10, 32'h0);
    idle(2);

    // Partial stores leave other lanes intact
    issue(1, 0, 2'd0, 0, 32'h11, 32'h000000AA);
    issue(0, 1, 2'd2, 0, 32'h10, 32'h0);
    issue(1, 0, 2'd1, 0, 32'h12, 32'h0000BEEF);
    issue(0, 1, 2'd2, 0, 32'h10, 32'h0);
    idle(2);

    // Rejected requests
    issue(0, 1, 2'd2, 0, 32'h12, 32'h0);
    idle(1);
    issue(1, 0, 2'd1, 0, 32'h11, 32'hDEAD);
    idle(1);
    issue(0, 1, 2'd3, 0, 32'h10, 32'h0);
    issue(1, 0, 2'd2, 0, 32'h3000, 32'hCAFEF00D);
    issue(1, 1, 2'd2, 0, 32'h12, 32'h12345678);
    issue(0, 1, 2'd2, 0, 32'h10, 32'h0);
    idle(2);

    // Simultaneous write and read returns pre-write data
    issue(1, 1, 2'd2, 0, 32'h20, 32'h11111111);
    issue(0, 1, 2'd2, 0, 32'h20, 32'h0);
    idle(2);

    // Randomized traffic
    for (int n = 0; n < 800; n++) begin
      r = $urandom_range(0, 15);
      if (r == 0)      a = 32'h2FF0 + 32'($urandom_range(0, 31));
      else if (r == 1) a = 32'($urandom);
      else             a = 32'($urandom_range(0, 63));
      r = $urandom_range(0, 9);
      sz = (r < 3) ? 2'd0 : (r < 6) ? 2'd1 : (r < 9) ? 2'd2 : 2'd3;
      issue(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), sz,
            1'($urandom_range(0, 1)), a, 32'($urandom));
      if ($urandom_range(0, 7) == 0) idle(1);
    end
    idle(3);

    // Reset with live data, requests during busy, reset again mid-clear
    reset_seq(2);
    repeat (100) issue(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 2'd2, 0,
                       32'($urandom_range(0, 15)) << 2, 32'($urandom));
    reset_seq(3);
    wait_clear();
    issue(0, 1, 2'd2, 0, 32'h0, 32'h0);
    issue(0, 1, 2'd2, 0, 32'h20, 32'h0);
    issue(0, 1, 2'd2, 0, 32'h2FFC, 32'h0);
    idle(3);

    if (q.size() != 0) check("queue_drained", 32'(q.size()), 32'h0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
